print_line_streamer: RTL and testbench

Sits directly downstream of `print_mechanism` and buffers each completed print line in a small line FIFO. It serialises every line into a framed byte stream with a valid/ready handshake for the host link (UART TX or USB bridge). Lines that arrive while the buffer is full are dropped and counted. Sequence numbers let the host detect any gap.

---
 rtl/print_mech_pkg.sv | 20 ++
 rtl/line_fifo.sv | 62 ++++++
 rtl/print_line_streamer.sv | 155 +++++++++++++++
 tb/tb_print_line_streamer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/print_mech_pkg.sv
// Shared definitions for the print line streaming path: frame constants,
// stream FSM states and the line FIFO entry width helper.
package print_mech_pkg;

    localparam logic [7:0]  FRAME_HEADER = 8'hA5;
    localparam int unsigned SEQ_WIDTH    = 8;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        SEQ,
        DATA
    } stream_state_t;

    // A FIFO entry is {seq, line}; seq occupies the top SEQ_WIDTH bits.
    function automatic int unsigned line_entry_width(input int unsigned head_width);
        return SEQ_WIDTH + head_width;
    endfunction

endpackage

// File: rtl/line_fifo.sv
// Registered-storage FIFO with wrap-around pointers (extra MSB for full/empty).
// Push and pop may occur together; a push into a full FIFO is accepted if a pop happens too.
module line_fifo #(
    parameter int unsigned WIDTH = 392,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/print_line_streamer.sv
// Buffers completed print lines and serialises each into an A5/seq/data byte
// frame on a registered valid/ready stream; overflowing lines are dropped and counted.
module print_line_streamer
    import print_mech_pkg::*;
#(
    parameter int unsigned HEAD_WIDTH = 384,
    parameter int unsigned LINE_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          print_line_ready,
    input  logic [HEAD_WIDTH-1:0]         print_line,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic [$clog2(LINE_DEPTH):0]   lines_pending,
    output logic [15:0]                   dropped_lines
);

    localparam int unsigned ENTRY_W = line_entry_width(HEAD_WIDTH);
    localparam int unsigned NBYTES  = HEAD_WIDTH / 8;
    localparam int unsigned IDX_W   = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    stream_state_t           state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [HEAD_WIDTH-1:0]   shift_q, shift_d;
    logic [7:0]              frame_seq_q, frame_seq_d;
    logic [7:0]              byte_data_q, byte_data_d;
    logic                    byte_valid_q, byte_valid_d;
    logic [7:0]              seq_cnt_q, seq_cnt_d;
    logic [15:0]             dropped_q, dropped_d;

    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ENTRY_W-1:0]      fifo_rd_data;
    logic                    load;

    line_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LINE_DEPTH)
    ) u_line_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (print_line_ready),
        .push_data ({seq_cnt_q, print_line}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (lines_pending)
    );

    assign byte_data     = byte_data_q;
    assign byte_valid    = byte_valid_q;
    assign dropped_lines = dropped_q;

    // Outside IDLE byte_valid_q is always set, so byte_ready alone marks a transfer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        frame_seq_d  = frame_seq_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = byte_valid_q;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            HEADER: begin
                if (byte_ready) begin
                    state_d     = SEQ;
                    byte_data_d = frame_seq_q;
                end
            end
            SEQ: begin
                if (byte_ready) begin
                    state_d     = DATA;
                    idx_d       = '0;
                    byte_data_d = shift_q[HEAD_WIDTH-1 -: 8];
                    shift_d     = shift_q << 8;
                end
            end
            DATA: begin
                if (byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d      = IDLE;
                            byte_valid_d = 1'b0;
                        end
                    end else begin
                        idx_d       = idx_q + IDX_W'(1);
                        byte_data_d = shift_q[HEAD_WIDTH-1 -: 8];
                        shift_d     = shift_q << 8;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                byte_valid_d = 1'b0;
            end
        endcase

        if (load) begin
            state_d      = HEADER;
            byte_valid_d = 1'b1;
            byte_data_d  = FRAME_HEADER;
            shift_d      = fifo_rd_data[HEAD_WIDTH-1:0];
            frame_seq_d  = fifo_rd_data[ENTRY_W-1 -: 8];
        end
    end

    assign fifo_pop = load;

    always_comb begin
        seq_cnt_d = seq_cnt_q;
        dropped_d = dropped_q;
        if (print_line_ready) begin
            seq_cnt_d = seq_cnt_q + 8'd1;
            if (fifo_full && !fifo_pop && (dropped_q != 16'hFFFF)) begin
                dropped_d = dropped_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shift_q      <= '0;
            frame_seq_q  <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            seq_cnt_q    <= '0;
            dropped_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            frame_seq_q  <= frame_seq_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            seq_cnt_q    <= seq_cnt_d;
            dropped_q    <= dropped_d;
        end
    end

endmodule

// File: tb/tb_print_line_streamer.sv
// Scoreboard bench for print_line_streamer with HEAD_WIDTH=16, LINE_DEPTH=4:
// directed stimulus pushes expected frame bytes, a negedge monitor pops and compares.
module tb_print_line_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        print_line_ready = 1'b0;
    logic [15:0] print_line = '0;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic [2:0]  lines_pending;
    logic [15:0] dropped_lines;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  model_seq = 8'd0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'd0;

    print_line_streamer #(
        .HEAD_WIDTH (16),
        .LINE_DEPTH (4)
    ) dut (
        .clk              (clk),
        .reset            (rst_n),
        .print_line_ready (print_line_ready),
        .print_line       (print_line),
        .byte_data        (byte_data),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .lines_pending    (lines_pending),
        .dropped_lines    (dropped_lines)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic [15:0] line, input bit dropped);
        if (!dropped) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(model_seq);
            exp_q.push_back(line[15:8]);
            exp_q.push_back(line[7:0]);
        end
        model_seq        = model_seq + 8'd1;
        print_line       = line;
        print_line_ready = 1'b1;
        tick();
        print_line_ready = 1'b0;
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || byte_valid) && cycles < 300) begin
            tick();
            cycles++;
        end
        n_tests++;
        if (cycles >= 300) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        model_seq = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_tests++;
                if (!(byte_valid === 1'b1 && byte_data === stall_data)) begin
                    n_fail++;
                    $display("FAIL stall_stable: got valid=%0b data=%0h, expected valid=1 data=%0h",
                             byte_valid, byte_data, stall_data);
                end
            end
            if (byte_valid && byte_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_byte: got unexpected %0h, expected no byte", byte_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (byte_data !== e) begin
                        n_fail++;
                        $display("FAIL stream_byte: got %0h, expected %0h", byte_data, e);
                    end
                end
            end
            stall_prev = byte_valid && !byte_ready;
            stall_data = byte_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset state
        tick();
        check("rst_valid", byte_valid, 0);
        check("rst_data", byte_data, 0);
        check("rst_pending", lines_pending, 0);
        check("rst_dropped", dropped_lines, 0);
        rst_n = 1'b1;
        tick();

        // Single line with latency check
        byte_ready = 1'b1;
        send_line(16'hBEEF, 0);
        check("lat_pending_1", lines_pending, 1);
        check("lat_valid_0", byte_valid, 0);
        tick();
        check("lat_valid_1", byte_valid, 1);
        check("lat_header", byte_data, 8'hA5);
        check("lat_pending_0", lines_pending, 0);
        wait_drain(cyc);
        check("single_cycles", cyc, 4);
        check("single_idle", byte_valid, 0);

        // Backpressure during SEQ byte
        byte_ready = 1'b0;
        send_line(16'hC0DE, 0);
        tick();
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", byte_valid, 1);
            check("bp_seq", byte_data, 8'h01);
            tick();
        end
        byte_ready = 1'b1;
        wait_drain(cyc);

        // Overflow: six strobes with sink stalled
        do_reset();
        byte_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send_line(16'(i), i == 6);
        end
        check("ovf_dropped", dropped_lines, 1);
        check("ovf_pending", lines_pending, 4);
        byte_ready = 1'b1;
        wait_drain(cyc);
        check("ovf_b2b_cycles", cyc, 20);

        // Full FIFO with push on the popping cycle
        byte_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_line(16'h0100 + 16'(i), 0);
        end
        check("full_pending", lines_pending, 4);
        byte_ready = 1'b1;
        tick();
        tick();
        tick();
        send_line(16'h0106, 0);
        check("pp_pending", lines_pending, 4);
        check("pp_dropped", dropped_lines, 1);
        wait_drain(cyc);
        check("pp_b2b_cycles", cyc, 20);
        check("pp_dropped_end", dropped_lines, 1);

        // Sequence wrap over 257 lines
        do_reset();
        byte_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            send_line(16'(i * 3 + 7), 0);
            tick();
            tick();
            tick();
        end
        wait_drain(cyc);
        check("wrap_dropped", dropped_lines, 0);

        // Reset mid-frame
        send_line(16'h5A5A, 0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", byte_valid, 0);
        check("mid_rst_data", byte_data, 0);
        check("mid_rst_pending", lines_pending, 0);
        check("mid_rst_dropped", dropped_lines, 0);
        exp_q.delete();
        model_seq = 8'd0;
        tick();
        rst_n = 1'b1;
        tick();
        send_line(16'h1357, 0);
        tick();
        check("post_rst_header", byte_data, 8'hA5);
        wait_drain(cyc);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
